// File: rtl/wb_arbiter_if.sv
// Writeback arbiter bus bundle: ALU result, long-latency handshake, register-file
// write port and hazard-side status. slave = arbiter, master = core/driver.
interface wb_arbiter_if #(
  parameter int DEPTH = 4
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic          alu_valid;
  logic [4:0]    alu_rd;
  logic [31:0]   alu_data;
  logic          ll_valid;
  logic          ll_ready;
  logic [4:0]    ll_rd;
  logic [31:0]   ll_data;
  logic          alu_stall;
  logic          rf_we;
  logic [4:0]    rf_waddr;
  logic [31:0]   rf_wdata;
  logic [CW-1:0] fifo_count;
  logic [31:0]   ll_pending;

  modport slave (
    input  alu_valid, alu_rd, alu_data, ll_valid, ll_rd, ll_data,
    output ll_ready, alu_stall, rf_we, rf_waddr, rf_wdata, fifo_count, ll_pending
  );

  modport master (
    output alu_valid, alu_rd, alu_data, ll_valid, ll_rd, ll_data,
    input  ll_ready, alu_stall, rf_we, rf_waddr, rf_wdata, fifo_count, ll_pending
  );
endinterface

// File: rtl/wb_arbiter.sv
// Merges single-cycle ALU results with buffered long-latency results onto one
// register-file write port, with a starvation guard and per-register pending mask.
module wb_arbiter #(
  parameter int DEPTH      = 4,
  parameter int STARVE_MAX = 8
) (
  input  logic        clk,
  input  logic        reset,
  wb_arbiter_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int WW = $clog2(STARVE_MAX + 1);

  typedef enum logic {NORMAL, FORCE} state_e;

  state_e        state_q, state_d;
  logic [4:0]    rd_mem_q   [DEPTH];
  logic [31:0]   data_mem_q [DEPTH];
  logic [AW-1:0] rptr_q, wptr_q;
  logic [CW-1:0] count_q, count_d;
  logic [WW-1:0] wait_q, wait_d;
  logic          stall_q, stall_d;
  logic          rf_we_q, rf_we_d;
  logic          rf_ll_q, rf_ll_d;
  logic [4:0]    rf_waddr_q, rf_waddr_d;
  logic [31:0]   rf_wdata_q, rf_wdata_d;
  logic          ready, nonempty, alu_sel, push, pop;
  logic [31:0]   pend;

  assign ready    = (count_q < CW'(DEPTH)) && !reset;
  assign nonempty = (count_q != '0);
  // ALU never wins in FORCE, so the head pops whenever the ALU does not take the slot.
  assign alu_sel  = (state_q == NORMAL) && bus.alu_valid && (bus.alu_rd != 5'd0);
  assign pop      = nonempty && !alu_sel;
  // rd=0 transfers complete the handshake but are dropped here.
  assign push     = bus.ll_valid && ready && (bus.ll_rd != 5'd0);

  always_comb begin
    count_d    = count_q + CW'(push) - CW'(pop);
    rf_we_d    = alu_sel || pop;
    rf_ll_d    = pop;
    rf_waddr_d = rf_waddr_q;
    rf_wdata_d = rf_wdata_q;
    if (alu_sel) begin
      rf_waddr_d = bus.alu_rd;
      rf_wdata_d = bus.alu_data;
    end else if (pop) begin
      rf_waddr_d = rd_mem_q[rptr_q];
      rf_wdata_d = data_mem_q[rptr_q];
    end
    wait_d  = (pop || !nonempty) ? '0 : wait_q + WW'(1);
    state_d = NORMAL;
    stall_d = 1'b0;
    if (state_q == NORMAL && wait_d == WW'(STARVE_MAX)) begin
      state_d = FORCE;
      stall_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= NORMAL;
      rptr_q     <= '0;
      wptr_q     <= '0;
      count_q    <= '0;
      wait_q     <= '0;
      stall_q    <= 1'b0;
      rf_we_q    <= 1'b0;
      rf_ll_q    <= 1'b0;
      rf_waddr_q <= '0;
      rf_wdata_q <= '0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      wait_q     <= wait_d;
      stall_q    <= stall_d;
      rf_we_q    <= rf_we_d;
      rf_ll_q    <= rf_ll_d;
      rf_waddr_q <= rf_waddr_d;
      rf_wdata_q <= rf_wdata_d;
      if (push) wptr_q <= wptr_q + AW'(1);
      if (pop)  rptr_q <= rptr_q + AW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      rd_mem_q[wptr_q]   <= bus.ll_rd;
      data_mem_q[wptr_q] <= bus.ll_data;
    end
  end

  // An entry is live when its distance from the read pointer is below the occupancy.
  always_comb begin : pend_c
    logic [AW-1:0] off;
    off  = '0;
    pend = '0;
    for (int i = 0; i < DEPTH; i++) begin
      off = AW'(i) - rptr_q;
      if ({1'b0, off} < count_q) pend[rd_mem_q[i]] = 1'b1;
    end
    if (rf_we_q && rf_ll_q) pend[rf_waddr_q] = 1'b1;
  end

  assign bus.ll_ready   = ready;
  assign bus.alu_stall  = stall_q;
  assign bus.rf_we      = rf_we_q;
  assign bus.rf_waddr   = rf_waddr_q;
  assign bus.rf_wdata   = rf_wdata_q;
  assign bus.fifo_count = count_q;
  assign bus.ll_pending = pend;
endmodule

// File: tb/tb_wb_arbiter.sv
// Directed bench for wb_arbiter: inputs change 1ns after the rising edge,
// outputs are sampled there too, against hand-computed expectations.
module tb_wb_arbiter;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int checks = 0;
  int errors = 0;

  wb_arbiter_if #(.DEPTH(4)) bus ();

  wb_arbiter #(.DEPTH(4), .STARVE_MAX(8)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.alu_valid = 1'b0; bus.alu_rd = 5'd0; bus.alu_data = 32'd0;
    bus.ll_valid  = 1'b0; bus.ll_rd  = 5'd0; bus.ll_data  = 32'd0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    idle();
    tick(); tick();
    checks++; if (bus.ll_ready !== 1'b0) begin errors++; $display("FAIL rst_ready: got %0b exp 0", bus.ll_ready); end
    checks++; if (bus.rf_we !== 1'b0) begin errors++; $display("FAIL rst_we: got %0b exp 0", bus.rf_we); end
    checks++; if (bus.rf_waddr !== 5'd0) begin errors++; $display("FAIL rst_waddr: got %0d exp 0", bus.rf_waddr); end
    checks++; if (bus.rf_wdata !== 32'd0) begin errors++; $display("FAIL rst_wdata: got %h exp 0", bus.rf_wdata); end
    checks++; if (bus.fifo_count !== 3'd0) begin errors++; $display("FAIL rst_count: got %0d exp 0", bus.fifo_count); end
    checks++; if (bus.ll_pending !== 32'd0) begin errors++; $display("FAIL rst_pending: got %h exp 0", bus.ll_pending); end
    checks++; if (bus.alu_stall !== 1'b0) begin errors++; $display("FAIL rst_stall: got %0b exp 0", bus.alu_stall); end
    reset = 1'b0;
    tick();
    checks++; if (bus.ll_ready !== 1'b1) begin errors++; $display("FAIL post_rst_ready: got %0b exp 1", bus.ll_ready); end
    checks++; if (bus.rf_we !== 1'b0) begin errors++; $display("FAIL post_rst_we: got %0b exp 0", bus.rf_we); end
  endtask

  task automatic test_alu();
    bus.alu_valid = 1'b1; bus.alu_rd = 5'd5; bus.alu_data = 32'hDEADBEEF;
    tick();
    idle();
    checks++; if (bus.rf_we !== 1'b1) begin errors++; $display("FAIL alu_we: got %0b exp 1", bus.rf_we); end
    checks++; if (bus.rf_waddr !== 5'd5) begin errors++; $display("FAIL alu_waddr: got %0d exp 5", bus.rf_waddr); end
    checks++; if (bus.rf_wdata !== 32'hDEADBEEF) begin errors++; $display("FAIL alu_wdata: got %h exp deadbeef", bus.rf_wdata); end
    bus.alu_valid = 1'b1; bus.alu_rd = 5'd0; bus.alu_data = 32'h11111111;
    tick();
    idle();
    checks++; if (bus.rf_we !== 1'b0) begin errors++; $display("FAIL alu_r0_we: got %0b exp 0", bus.rf_we); end
    checks++; if (bus.rf_waddr !== 5'd5) begin errors++; $display("FAIL alu_r0_hold_addr: got %0d exp 5", bus.rf_waddr); end
    checks++; if (bus.rf_wdata !== 32'hDEADBEEF) begin errors++; $display("FAIL alu_r0_hold_data: got %h exp deadbeef", bus.rf_wdata); end
  endtask

  task automatic test_ll_single();
    bus.ll_valid = 1'b1; bus.ll_rd = 5'd7; bus.ll_data = 32'h00001234;
    checks++; if (bus.ll_ready !== 1'b1) begin errors++; $display("FAIL ll1_ready: got %0b exp 1", bus.ll_ready); end
    tick();
    idle();
    checks++; if (bus.ll_pending !== 32'h80) begin errors++; $display("FAIL ll1_pend_rise: got %h exp 80", bus.ll_pending); end
    checks++; if (bus.fifo_count !== 3'd1) begin errors++; $display("FAIL ll1_count: got %0d exp 1", bus.fifo_count); end
    checks++; if (bus.rf_we !== 1'b0) begin errors++; $display("FAIL ll1_we_early: got %0b exp 0", bus.rf_we); end
    tick();
    checks++; if (bus.rf_we !== 1'b1) begin errors++; $display("FAIL ll1_we: got %0b exp 1", bus.rf_we); end
    checks++; if (bus.rf_waddr !== 5'd7) begin errors++; $display("FAIL ll1_waddr: got %0d exp 7", bus.rf_waddr); end
    checks++; if (bus.rf_wdata !== 32'h1234) begin errors++; $display("FAIL ll1_wdata: got %h exp 1234", bus.rf_wdata); end
    checks++; if (bus.ll_pending !== 32'h80) begin errors++; $display("FAIL ll1_pend_held: got %h exp 80", bus.ll_pending); end
    checks++; if (bus.fifo_count !== 3'd0) begin errors++; $display("FAIL ll1_count_pop: got %0d exp 0", bus.fifo_count); end
    tick();
    checks++; if (bus.ll_pending !== 32'h0) begin errors++; $display("FAIL ll1_pend_fall: got %h exp 0", bus.ll_pending); end
  endtask

  task automatic test_back_to_back();
    // Duplicate rd=3 pushed on consecutive cycles; push and pop overlap on the second.
    bus.ll_valid = 1'b1; bus.ll_rd = 5'd3; bus.ll_data = 32'hA;
    tick();
    bus.ll_data = 32'hB;
    tick();
    idle();
    checks++; if (bus.fifo_count !== 3'd1) begin errors++; $display("FAIL b2b_count: got %0d exp 1", bus.fifo_count); end
    checks++; if (bus.rf_wdata !== 32'hA) begin errors++; $display("FAIL b2b_first: got %h exp a", bus.rf_wdata); end
    checks++; if (bus.ll_pending !== 32'h8) begin errors++; $display("FAIL b2b_pend1: got %h exp 8", bus.ll_pending); end
    tick();
    checks++; if (bus.rf_wdata !== 32'hB || bus.rf_waddr !== 5'd3) begin errors++; $display("FAIL b2b_second: got %0d/%h exp 3/b", bus.rf_waddr, bus.rf_wdata); end
    checks++; if (bus.ll_pending !== 32'h8) begin errors++; $display("FAIL b2b_pend2: got %h exp 8", bus.ll_pending); end
    tick();
    checks++; if (bus.ll_pending !== 32'h0) begin errors++; $display("FAIL b2b_pend3: got %h exp 0", bus.ll_pending); end
  endtask

  task automatic test_full();
    bus.alu_valid = 1'b1; bus.alu_rd = 5'd20; bus.alu_data = 32'h20;
    for (int i = 1; i <= 4; i++) begin
      bus.ll_valid = 1'b1; bus.ll_rd = 5'(i); bus.ll_data = 32'h100 + 32'(i);
      tick();
    end
    checks++; if (bus.fifo_count !== 3'd4) begin errors++; $display("FAIL full_count: got %0d exp 4", bus.fifo_count); end
    checks++; if (bus.ll_ready !== 1'b0) begin errors++; $display("FAIL full_ready: got %0b exp 0", bus.ll_ready); end
    checks++; if (bus.ll_pending !== 32'h1E) begin errors++; $display("FAIL full_pend: got %h exp 1e", bus.ll_pending); end
    checks++; if (bus.rf_we !== 1'b1 || bus.rf_waddr !== 5'd20) begin errors++; $display("FAIL full_alu_wr: got %0b/%0d exp 1/20", bus.rf_we, bus.rf_waddr); end
    bus.ll_rd = 5'd5; bus.ll_data = 32'h105;
    tick();
    checks++; if (bus.fifo_count !== 3'd4) begin errors++; $display("FAIL full_5th_count: got %0d exp 4", bus.fifo_count); end
    checks++; if (bus.ll_pending !== 32'h1E) begin errors++; $display("FAIL full_5th_pend: got %h exp 1e", bus.ll_pending); end
    idle();
    for (int i = 1; i <= 4; i++) begin
      tick();
      checks++; if (bus.rf_waddr !== 5'(i) || bus.rf_wdata !== 32'h100 + 32'(i)) begin errors++; $display("FAIL drain_%0d: got %0d/%h exp %0d/%h", i, bus.rf_waddr, bus.rf_wdata, i, 32'h100 + 32'(i)); end
    end
    checks++; if (bus.fifo_count !== 3'd0) begin errors++; $display("FAIL drain_count: got %0d exp 0", bus.fifo_count); end
    bus.ll_valid = 1'b1; bus.ll_rd = 5'd0; bus.ll_data = 32'hBAD;
    tick();
    idle();
    checks++; if (bus.fifo_count !== 3'd0) begin errors++; $display("FAIL r0_push_count: got %0d exp 0", bus.fifo_count); end
    checks++; if (bus.ll_pending !== 32'h0) begin errors++; $display("FAIL r0_push_pend: got %h exp 0", bus.ll_pending); end
    tick();
    checks++; if (bus.rf_we !== 1'b0) begin errors++; $display("FAIL r0_push_we: got %0b exp 0", bus.rf_we); end
  endtask

  task automatic test_starve();
    logic exp_stall;
    bus.alu_valid = 1'b1; bus.alu_rd = 5'd11; bus.alu_data = 32'h11;
    bus.ll_valid = 1'b1; bus.ll_rd = 5'd9; bus.ll_data = 32'h99;
    tick();
    bus.ll_valid = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      tick();
      exp_stall = (k == 8);
      checks++; if (bus.alu_stall !== exp_stall) begin errors++; $display("FAIL starve_stall_%0d: got %0b exp %0b", k, bus.alu_stall, exp_stall); end
    end
    checks++; if (bus.rf_waddr !== 5'd11) begin errors++; $display("FAIL starve_alu_wr: got %0d exp 11", bus.rf_waddr); end
    bus.alu_valid = 1'b0;
    tick();
    checks++; if (bus.rf_we !== 1'b1 || bus.rf_waddr !== 5'd9 || bus.rf_wdata !== 32'h99) begin errors++; $display("FAIL starve_drain: got %0b/%0d/%h exp 1/9/99", bus.rf_we, bus.rf_waddr, bus.rf_wdata); end
    checks++; if (bus.alu_stall !== 1'b0) begin errors++; $display("FAIL starve_release: got %0b exp 0", bus.alu_stall); end
    checks++; if (bus.fifo_count !== 3'd0) begin errors++; $display("FAIL starve_count: got %0d exp 0", bus.fifo_count); end
    bus.alu_valid = 1'b1; bus.alu_rd = 5'd12; bus.alu_data = 32'h12;
    tick();
    idle();
    checks++; if (bus.rf_we !== 1'b1 || bus.rf_waddr !== 5'd12) begin errors++; $display("FAIL starve_resume: got %0b/%0d exp 1/12", bus.rf_we, bus.rf_waddr); end
  endtask

  task automatic test_reset_flush();
    bus.alu_valid = 1'b1; bus.alu_rd = 5'd13; bus.alu_data = 32'h13;
    for (int i = 2; i <= 4; i++) begin
      bus.ll_valid = 1'b1; bus.ll_rd = 5'(i); bus.ll_data = 32'(i);
      tick();
    end
    checks++; if (bus.fifo_count !== 3'd3) begin errors++; $display("FAIL flush_pre_count: got %0d exp 3", bus.fifo_count); end
    checks++; if (bus.ll_pending !== 32'h1C) begin errors++; $display("FAIL flush_pre_pend: got %h exp 1c", bus.ll_pending); end
    idle();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checks++; if (bus.fifo_count !== 3'd0) begin errors++; $display("FAIL flush_count: got %0d exp 0", bus.fifo_count); end
    checks++; if (bus.ll_pending !== 32'h0) begin errors++; $display("FAIL flush_pend: got %h exp 0", bus.ll_pending); end
    for (int k = 0; k < 3; k++) begin
      tick();
      checks++; if (bus.rf_we !== 1'b0) begin errors++; $display("FAIL flush_no_wr_%0d: got %0b exp 0", k, bus.rf_we); end
    end
  endtask

  initial begin
    idle();
    test_reset();
    test_alu();
    test_ll_single();
    test_back_to_back();
    test_full();
    test_starve();
    test_reset_flush();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
